// File: rtl/switch_port_receiver.sv
// Output-port receiver for the 4-port switch: drains the port with the ready/read
// handshake, parses DA/SA/LEN/payload/FCS, streams the payload and flags errors.
module switch_port_receiver #(
  parameter int unsigned MAX_LEN   = 255,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_addr,
  input  logic                 ready,
  output logic                 read,
  input  logic [7:0]           data,
  output logic                 pl_valid,
  output logic [7:0]           pl_data,
  output logic                 pkt_done,
  output logic [7:0]           pkt_da,
  output logic [7:0]           pkt_sa,
  output logic [7:0]           pkt_len,
  output logic                 err_addr,
  output logic                 err_len,
  output logic                 err_fcs,
  output logic [ERR_CNT_W-1:0] pkt_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DA, ST_SA, ST_LEN, ST_PAY, ST_FCS, ST_DRAIN, ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  read_q, read_d;
  logic                  dv_q, dv_d;
  logic                  pkt_done_q, pkt_done_d;
  logic [7:0]            da_q, da_d;
  logic [7:0]            sa_q, sa_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            acc_q, acc_d;
  logic                  err_addr_q, err_addr_d;
  logic                  err_len_q, err_len_d;
  logic                  err_fcs_q, err_fcs_d;
  logic [ERR_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Next-state, field capture, FCS accumulation and counter update
  always_comb begin
    state_d    = state_q;
    dv_d       = read_q & ready;
    pkt_done_d = 1'b0;
    da_d       = da_q;
    sa_d       = sa_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    err_addr_d = err_addr_q;
    err_len_d  = err_len_q;
    err_fcs_d  = err_fcs_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ready) begin
          state_d   = ST_DA;
          da_d      = 8'd0;
          sa_d      = 8'd0;
          len_d     = 8'd0;
          cnt_d     = 8'd0;
          acc_d     = 8'd0;
          err_len_d = 1'b0;
          err_fcs_d = 1'b0;
        end
      end
      ST_DA: begin
        if (dv_q) begin
          da_d       = data;
          err_addr_d = (data != port_addr);
          acc_d      = acc_q ^ data;
          state_d    = ST_SA;
        end else if (!ready) begin
          err_len_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_SA: begin
        if (dv_q) begin
          sa_d    = data;
          acc_d   = acc_q ^ data;
          state_d = ST_LEN;
        end else if (!ready) begin
          err_len_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_LEN: begin
        if (dv_q) begin
          len_d = data;
          cnt_d = data;
          acc_d = acc_q ^ data;
          if (data == 8'd0 || 32'(data) > MAX_LEN) begin
            err_len_d = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_PAY;
          end
        end else if (!ready) begin
          err_len_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_PAY: begin
        if (dv_q) begin
          acc_d = acc_q ^ data;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_FCS;
        end else if (!ready) begin
          err_len_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_FCS: begin
        if (dv_q) begin
          err_fcs_d = (data != acc_q);
          // switch still offering bytes after the FCS means the packet overran LEN
          if (ready) begin
            err_len_d = 1'b1;
            state_d   = ST_DRAIN;
          end else begin
            state_d = ST_DONE;
          end
        end else if (!ready) begin
          err_len_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (!ready && !dv_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    read_d = ready && (state_d != ST_IDLE) && (state_d != ST_DONE);

    if (state_d == ST_DONE) begin
      pkt_done_d = 1'b1;
      if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + ERR_CNT_W'(1);
      if ((err_addr_d || err_len_d || err_fcs_d) && err_cnt_q != '1)
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      read_q     <= 1'b0;
      dv_q       <= 1'b0;
      pkt_done_q <= 1'b0;
      da_q       <= 8'd0;
      sa_q       <= 8'd0;
      len_q      <= 8'd0;
      cnt_q      <= 8'd0;
      acc_q      <= 8'd0;
      err_addr_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_fcs_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      dv_q       <= dv_d;
      pkt_done_q <= pkt_done_d;
      da_q       <= da_d;
      sa_q       <= sa_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      err_addr_q <= err_addr_d;
      err_len_q  <= err_len_d;
      err_fcs_q  <= err_fcs_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Payload passes straight through on the cycle its byte is valid
  assign pl_valid = (state_q == ST_PAY) && dv_q;
  assign pl_data  = pl_valid ? data : 8'd0;

  assign read     = read_q;
  assign pkt_done = pkt_done_q;
  assign pkt_da   = da_q;
  assign pkt_sa   = sa_q;
  assign pkt_len  = len_q;
  assign err_addr = err_addr_q;
  assign err_len  = err_len_q;
  assign err_fcs  = err_fcs_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_switch_port_receiver.sv
// Directed bench for switch_port_receiver: a byte-queue switch model feeds packets,
// a negedge monitor collects payload and pkt_done flags.
module tb_switch_port_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_addr;
  logic       ready;
  logic       read;
  logic [7:0] data;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pkt_done;
  logic [7:0] pkt_da, pkt_sa, pkt_len;
  logic       err_addr, err_len, err_fcs;
  logic [7:0] pkt_cnt, err_cnt;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] sw_q[$];
  logic [7:0] pl_got[$];
  int         done_cnt = 0;
  logic       f_addr, f_len, f_fcs;

  switch_port_receiver #(.MAX_LEN(255), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .port_addr(port_addr), .ready(ready), .read(read),
    .data(data), .pl_valid(pl_valid), .pl_data(pl_data), .pkt_done(pkt_done),
    .pkt_da(pkt_da), .pkt_sa(pkt_sa), .pkt_len(pkt_len), .err_addr(err_addr),
    .err_len(err_len), .err_fcs(err_fcs), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pl_valid) pl_got.push_back(pl_data);
    if (pkt_done) begin
      done_cnt = done_cnt + 1;
      f_addr   = err_addr;
      f_len    = err_len;
      f_fcs    = err_fcs;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plays sw_q through the handshake until pkt_done; optional reset after rst_after payload bytes
  task automatic drive_pkt(input int rst_after, output int npl, output int ndone);
    bit xfer;
    int start_done = done_cnt;
    int pl_base    = pl_got.size();
    int guard      = 0;
    bit aborted    = 1'b0;
    @(posedge clk); #1;
    ready = (sw_q.size() > 0);
    while (done_cnt == start_done && guard < 300 && !aborted) begin
      @(negedge clk);
      xfer = read && ready;
      @(posedge clk); #1;
      if (rst_after != 0 && (pl_got.size() - pl_base) >= rst_after) begin
        reset = 1'b1;
        ready = 1'b0;
        sw_q.delete();
        @(posedge clk); #1;
        reset   = 1'b0;
        aborted = 1'b1;
      end else begin
        if (xfer) data = sw_q.pop_front();
        ready = (sw_q.size() > 0);
      end
      guard++;
    end
    if (!aborted) chk("pkt_done_seen", 32'(done_cnt - start_done), 32'd1);
    npl   = pl_got.size() - pl_base;
    ndone = done_cnt - start_done;
  endtask

  task automatic check_flags(input string tag, input logic ea, input logic el, input logic ef,
                             input int pc, input int ec);
    chk({tag, "_err_addr"}, 32'(f_addr), 32'(ea));
    chk({tag, "_err_len"},  32'(f_len),  32'(el));
    chk({tag, "_err_fcs"},  32'(f_fcs),  32'(ef));
    chk({tag, "_pkt_cnt"},  32'(pkt_cnt), 32'(pc));
    chk({tag, "_err_cnt"},  32'(err_cnt), 32'(ec));
  endtask

  initial begin
    int npl, nd;
    reset     = 1'b1;
    ready     = 1'b0;
    data      = 8'h00;
    port_addr = 8'h12;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_read",     32'(read),     32'd0);
    chk("rst_pl_valid", 32'(pl_valid), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_pkt_cnt",  32'(pkt_cnt),  32'd0);
    chk("rst_err_cnt",  32'(err_cnt),  32'd0);

    // Good packet: FCS = 12^34^03^AA^BB^CC = F8
    sw_q = '{8'h12, 8'h34, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hF8};
    drive_pkt(0, npl, nd);
    chk("good_npl", 32'(npl), 32'd3);
    if (pl_got.size() >= 3) begin
      chk("good_pl0", 32'(pl_got[pl_got.size()-3]), 32'hAA);
      chk("good_pl1", 32'(pl_got[pl_got.size()-2]), 32'hBB);
      chk("good_pl2", 32'(pl_got[pl_got.size()-1]), 32'hCC);
    end
    check_flags("good", 1'b0, 1'b0, 1'b0, 1, 0);
    chk("good_da",  32'(pkt_da),  32'h12);
    chk("good_sa",  32'(pkt_sa),  32'h34);
    chk("good_len", 32'(pkt_len), 32'h03);
    repeat (2) @(posedge clk);
    #1 chk("done_pulse_once", 32'(done_cnt), 32'd1);

    // Bad FCS
    sw_q = '{8'h12, 8'h34, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    drive_pkt(0, npl, nd);
    chk("badfcs_npl", 32'(npl), 32'd3);
    check_flags("badfcs", 1'b0, 1'b0, 1'b1, 2, 1);

    // Wrong address: FCS = 55^34^03^AA^BB^CC = BF
    sw_q = '{8'h55, 8'h34, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hBF};
    drive_pkt(0, npl, nd);
    check_flags("addr", 1'b1, 1'b0, 1'b0, 3, 2);
    chk("addr_da", 32'(pkt_da), 32'h55);

    // Short: LEN=5, only two payload bytes
    sw_q = '{8'h12, 8'h34, 8'h05, 8'h01, 8'h02};
    drive_pkt(0, npl, nd);
    chk("short_npl", 32'(npl), 32'd2);
    check_flags("short", 1'b0, 1'b1, 1'b0, 4, 3);
    chk("short_len", 32'(pkt_len), 32'h05);

    // Long: LEN=2, four payload bytes; surplus must be drained with read held
    sw_q = '{8'h12, 8'h34, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    drive_pkt(0, npl, nd);
    chk("long_npl", 32'(npl), 32'd2);
    if (pl_got.size() >= 1) chk("long_last_pl", 32'(pl_got[pl_got.size()-1]), 32'h22);
    chk("long_drained", 32'(sw_q.size()), 32'd0);
    chk("long_err_len", 32'(f_len), 32'd1);
    chk("long_cnts", 32'({pkt_cnt, err_cnt}), 32'h0504);
    chk("long_read_low", 32'(read), 32'd0);

    // Zero length
    sw_q = '{8'h12, 8'h34, 8'h00, 8'h26};
    drive_pkt(0, npl, nd);
    chk("zero_npl", 32'(npl), 32'd0);
    chk("zero_err_len", 32'(f_len), 32'd1);
    chk("zero_err_addr", 32'(f_addr), 32'd0);
    chk("zero_len", 32'(pkt_len), 32'h00);
    chk("zero_drained", 32'(sw_q.size()), 32'd0);
    chk("zero_cnts", 32'({pkt_cnt, err_cnt}), 32'h0605);

    // Reset during payload byte 2 of a LEN=4 packet
    sw_q = '{8'h12, 8'h34, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h22};
    drive_pkt(1, npl, nd);
    chk("rstmid_no_done", 32'(nd),       32'd0);
    chk("rstmid_read",    32'(read),     32'd0);
    chk("rstmid_pl",      32'(pl_valid), 32'd0);
    chk("rstmid_pkt_cnt", 32'(pkt_cnt),  32'd0);
    chk("rstmid_err_cnt", 32'(err_cnt),  32'd0);
    chk("rstmid_len",     32'(pkt_len),  32'd0);
    repeat (3) @(posedge clk);
    #1 chk("rstmid_no_done_later", 32'(pkt_done), 32'd0);

    sw_q = '{8'h12, 8'h34, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hF8};
    drive_pkt(0, npl, nd);
    chk("after_rst_npl", 32'(npl), 32'd3);
    check_flags("after_rst", 1'b0, 1'b0, 1'b0, 1, 0);

    // Saturation: 300 more good packets, FCS = 12^34^01^5A = 7D
    for (int i = 0; i < 300; i++) begin
      sw_q = '{8'h12, 8'h34, 8'h01, 8'h5A, 8'h7D};
      drive_pkt(0, npl, nd);
      if (i == 252) chk("sat_pre", 32'(pkt_cnt), 32'd254);
    end
    chk("sat_pkt_cnt", 32'(pkt_cnt), 32'd255);
    chk("sat_err_cnt", 32'(err_cnt), 32'd0);
    chk("sat_flags", 32'({f_addr, f_len, f_fcs}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
